// File: rtl/sram_stream_reader_pkg.sv
// Shared definitions for the SRAM stream reader.
//   state_t   : reader FSM encoding (IDLE, READ, DRAIN)
//   BUF_DEPTH : number of entries in the output buffer
package sram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/sram_stream_reader_fifo2.sv
// fifo2: two-entry valid/ready FIFO used as the reader's output buffer.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   in_valid/in_ready push side handshake, in_data pushed word
//   out_valid/out_ready pop side handshake, out_data head word
//   occupancy         number of stored words (0..2)
// Handshake: a word moves on a side when valid and ready are both high at
// the rising clock edge; valid never depends on ready of the same side.
module fifo2
  import sram_stream_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  // A full buffer may still accept a word when the head leaves in the same cycle.
  assign in_ready  = (count != 2'(BUF_DEPTH)) || out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign occupancy = count;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_stream_reader.sv
// sram_stream_reader: reads cmd_count consecutive SRAM rows starting at
// cmd_start (wrapping at NUM_ROWS) and streams them out in address order.
// Ports:
//   CLK, RST                        clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake; cmd_start, cmd_count
//   out_valid/out_ready             output handshake; out_data, out_last
//   busy                            command in progress
//   sram_ceb/web/a/d/m, sram_q      SRAM read port (read data one cycle later)
//   dbg_state                       current FSM state
// Handshake: a transfer happens when valid and ready are both high at the
// rising clock edge; valid never waits for ready, and once valid is high the
// payload holds until the transfer.
module sram_stream_reader
  import sram_stream_pkg::*;
#(
  parameter  int WIDTH         = 128,
  parameter  int NUM_ROWS      = 4096,
  localparam int ADDRESS_WIDTH = $clog2(NUM_ROWS)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_start,
  input  logic [ADDRESS_WIDTH:0]   cmd_count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     sram_ceb,
  output logic                     sram_web,
  output logic [ADDRESS_WIDTH-1:0] sram_a,
  output logic [WIDTH-1:0]         sram_d,
  output logic [WIDTH-1:0]         sram_m,
  input  logic [WIDTH-1:0]         sram_q,
  output state_t                   dbg_state
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ROW = ADDRESS_WIDTH'(NUM_ROWS - 1);

  state_t                   state;
  state_t                   next_state;
  logic [ADDRESS_WIDTH-1:0] row;
  logic [ADDRESS_WIDTH:0]   remaining;
  logic                     inflight;
  logic                     inflight_last;
  logic                     accept;
  logic                     issue;
  logic                     issue_last;
  logic                     pop;
  logic [2:0]               pending;
  logic                     buf_in_ready;
  logic                     buf_out_valid;
  logic [WIDTH:0]           buf_out;
  logic [1:0]               occ;
  logic                     capture;

  assign accept = cmd_valid & cmd_ready;
  assign pop    = buf_out_valid & out_ready;

  // Words that will occupy the buffer after this edge if no read issues now.
  // Keeping this below the buffer depth before issuing guarantees the read
  // data always finds a free slot next cycle.
  assign pending    = 3'(occ) + 3'(inflight) - 3'(pop);
  assign issue      = (state == READ) && (remaining != '0) && (pending < 3'(BUF_DEPTH));
  assign issue_last = issue && (remaining == (ADDRESS_WIDTH+1)'(1));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && (cmd_count != '0)) next_state = READ;
      READ:    if (issue_last) next_state = DRAIN;
      DRAIN:   if (pop && buf_out[WIDTH]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    cmd_ready = 1'b1;
      READ:    busy      = 1'b1;
      DRAIN:   busy      = 1'b1;
      default: begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Row/remaining counters and the in-flight read flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      row           <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue_last;
      if ((state == IDLE) && accept) begin
        row       <= cmd_start;
        remaining <= cmd_count;
      end else if (issue) begin
        row       <= (row == LAST_ROW) ? '0 : row + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  // sram_q is only looked at in the cycle after an issued read.
  assign capture = inflight & buf_in_ready;

  fifo2 #(
    .WIDTH(WIDTH + 1)
  ) u_buf (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (capture),
    .in_ready (buf_in_ready),
    .in_data  ({inflight_last, sram_q}),
    .out_valid(buf_out_valid),
    .out_ready(out_ready),
    .out_data (buf_out),
    .occupancy(occ)
  );

  assign out_valid = buf_out_valid;
  assign out_data  = buf_out[WIDTH-1:0];
  assign out_last  = buf_out_valid & buf_out[WIDTH];

  assign sram_ceb  = issue;
  assign sram_web  = 1'b0;
  assign sram_a    = row;
  assign sram_d    = '0;
  assign sram_m    = '0;
  assign dbg_state = state;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader with a row-index SRAM model.
module tb_sram_stream_reader;
  import sram_stream_pkg::*;

  localparam int W  = 32;
  localparam int NR = 64;
  localparam int AW = 6;

  // ---------------- clock / reset / signals ----------------
  logic          CLK = 1'b0;
  logic          RST;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_start;
  logic [AW:0]   cmd_count;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          busy;
  logic          sram_ceb;
  logic          sram_web;
  logic [AW-1:0] sram_a;
  logic [W-1:0]  sram_d;
  logic [W-1:0]  sram_m;
  logic [W-1:0]  sram_q;
  state_t        dbg_state;

  always #5 CLK = ~CLK;

  sram_stream_reader #(.WIDTH(W), .NUM_ROWS(NR)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_count(cmd_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a),
    .sram_d(sram_d), .sram_m(sram_m), .sram_q(sram_q),
    .dbg_state(dbg_state)
  );

  // SRAM model: row r holds value r; junk on cycles without a read.
  always @(posedge CLK) sram_q <= sram_ceb ? W'(sram_a) : W'($urandom);

  // ---------------- scoreboard ----------------
  logic [W:0]   exp_q[$];
  int           n_checks   = 0;
  int           n_fail     = 0;
  int           words_seen = 0;
  int           outst      = 0;
  logic         tie_bad    = 1'b0;
  logic         prev_hold  = 1'b0;
  logic [W-1:0] prev_data  = '0;
  logic         prev_last  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (RST) begin
      prev_hold = 1'b0;
      outst     = 0;
    end else begin
      if (sram_web !== 1'b0 || sram_d !== '0 || sram_m !== '0) tie_bad = 1'b1;
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        chk("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          logic [W:0] e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e[W-1:0]);
          chk("out_last", out_last, e[W]);
        end
        words_seen++;
      end
      outst = outst + int'(sram_ceb) - int'(out_valid && out_ready);
      if (sram_ceb) chk("outstanding_le_2", outst <= 2, 1);
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input int start, input int count);
    int i;
    @(posedge CLK); #1;
    cmd_valid = 1'b1;
    cmd_start = AW'(start);
    cmd_count = (AW+1)'(count);
    for (i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (cmd_ready) break;
    end
    chk("cmd_accept_in_time", i < 20, 1);
    for (int k = 0; k < count; k++) begin
      exp_q.push_back({(k == count - 1), W'((start + k) % NR)});
    end
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge CLK);
      if (!busy && exp_q.size() == 0) break;
    end
    chk(tag, i < limit, 1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sram_ceb"}, sram_ceb, 0);
    chk({tag, "_sram_a"}, sram_a, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_state"}, dbg_state, IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    logic bad_ready, bad_ceb, bad_valid;
    RST       = 1'b1;
    cmd_valid = 1'b0;
    cmd_start = '0;
    cmd_count = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check_idle("reset");

    // Start=5, count=4: latency and back-to-back delivery.
    @(posedge CLK); #1 out_ready = 1'b1;
    send_cmd(5, 4);
    @(negedge CLK);
    chk("lat_n1_ceb", sram_ceb, 1);
    chk("lat_n1_addr", sram_a, 5);
    chk("lat_n1_busy", busy, 1);
    chk("lat_n1_cmd_ready", cmd_ready, 0);
    chk("lat_n1_out_valid", out_valid, 0);
    chk("lat_n1_state", dbg_state, READ);
    @(negedge CLK);
    chk("lat_n2_out_valid", out_valid, 0);
    chk("lat_n2_addr", sram_a, 6);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("stream_out_valid", out_valid, 1);
      if (k == 0) chk("lat_n3_data", out_data, 5);
      if (k == 2) chk("drain_state", dbg_state, DRAIN);
    end
    @(negedge CLK);
    chk("t1_done_busy", busy, 0);
    chk("t1_done_out_valid", out_valid, 0);
    chk("t1_done_state", dbg_state, IDLE);
    chk("t1_queue_empty", exp_q.size(), 0);

    // Wrap: rows 62, 63, 0, 1.
    send_cmd(NR - 2, 4);
    wait_idle("t2_wrap_done", 50);

    // 16 words with random backpressure and two 10-cycle stalls.
    send_cmd(20, 16);
    begin
      int c;
      for (c = 0; c < 400; c++) begin
        @(posedge CLK); #1;
        out_ready = ((c >= 3 && c < 13) || (c >= 25 && c < 35)) ? 1'b0 : 1'($urandom_range(0, 1));
        @(negedge CLK);
        if (!busy && exp_q.size() == 0) break;
      end
      chk("t3_stall_done", c < 400, 1);
    end
    @(posedge CLK); #1 out_ready = 1'b1;

    // Zero-length command.
    send_cmd(7, 0);
    bad_ready = 1'b0;
    bad_ceb   = 1'b0;
    bad_valid = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      bad_ready |= !cmd_ready;
      bad_ceb   |= sram_ceb;
      bad_valid |= out_valid;
    end
    chk("t4_cmd_ready_dropped", bad_ready, 0);
    chk("t4_sram_ceb_seen", bad_ceb, 0);
    chk("t4_out_valid_seen", bad_valid, 0);

    // Reset after 3 of 8 words.
    base = words_seen;
    send_cmd(10, 8);
    begin
      int i;
      for (i = 0; i < 50; i++) begin
        @(posedge CLK);
        if (words_seen == base + 3) break;
      end
      chk("t5_three_words", i < 50, 1);
    end
    #1;
    RST       = 1'b1;
    out_ready = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    check_idle("post_rst");
    @(posedge CLK); #1 out_ready = 1'b1;
    bad_valid = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      bad_valid |= out_valid;
    end
    chk("t5_no_stale_word", bad_valid, 0);
    send_cmd(0, 2);
    wait_idle("t5_new_cmd_done", 50);
    chk("t5_word_count", words_seen, base + 5);

    // Full sweep of all rows.
    base = words_seen;
    send_cmd(0, NR);
    wait_idle("t6_sweep_done", 300);
    chk("t6_word_count", words_seen, base + NR);
    chk("t6_tied_outputs", tie_bad, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_stream_reader.md
SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

Interface
REQ-001 Parameter WIDTH, default 128, SHALL give the word width in bits.
REQ-002 Parameter NUM_ROWS, default 4096, SHALL give the SRAM depth; localparam ADDRESS_WIDTH = $clog2(NUM_ROWS).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: CLK  input  1  clock, all logic on rising edge; RST  input  1  synchronous active-high reset.
REQ-004 cmd_valid  input  1  command offered; cmd_ready  output  1  command accepted when both high.
REQ-005 cmd_start  input  ADDRESS_WIDTH  first row to read; cmd_count  input  ADDRESS_WIDTH+1  number of rows to read, 0..NUM_ROWS.
REQ-006 out_valid  output  1  word available; out_ready  input  1  consumer accepts; out_data  output  WIDTH  read word; out_last  output  1  final word of command.
REQ-007 busy  output  1  command in progress.
REQ-008 sram_ceb  output  1  SRAM enable, active high; sram_web  output  1  SRAM write enable, tied 0; sram_a  output  ADDRESS_WIDTH  SRAM row; sram_d  output  WIDTH  tied 0; sram_m  output  WIDTH  tied 0; sram_q  input  WIDTH  SRAM read data, valid the cycle after sram_ceb.

Function
REQ-009 FSM states SHALL be IDLE, READ, DRAIN; cmd_ready SHALL be 1 only in IDLE; busy SHALL be 1 in READ and DRAIN.
REQ-010 IDLE -> READ on cmd_valid & cmd_ready with cmd_count > 0; cmd_count = 0 SHALL be accepted, produce no SRAM access and no output, and stay in IDLE.
REQ-011 In READ, a read SHALL issue (sram_ceb=1, sram_a=current row) iff rows remain and buffer occupancy + in-flight reads - (out_valid & out_ready) < 2.
REQ-012 The row address SHALL increment by 1 per issued read and wrap from NUM_ROWS-1 to 0.
REQ-013 READ -> DRAIN in the cycle after the last read issues; DRAIN -> IDLE on handshake of the word with out_last=1.
REQ-014 sram_q SHALL be captured into the 2-entry output buffer only in the cycle after an issued read; sram_q SHALL be ignored at all other times.
REQ-015 Latency: with out_ready=1, command accepted in cycle N -> first sram_ceb in N+1 -> first out_valid in N+3.
REQ-016 With out_ready held 1, sustained throughput SHALL be one word per cycle with no bubbles after the first word.
REQ-017 Words SHALL be delivered in address order with no loss or duplication under any out_ready pattern.
REQ-018 While out_valid=1 and out_ready=0, out_data and out_last SHALL remain stable.
REQ-019 out_last SHALL be 1 only on the cmd_count-th word of the command.
REQ-020 The buffer SHALL never overflow; simultaneous capture and pop on a full buffer SHALL be handled correctly.

Reset
REQ-021 While RST=1 at a clock edge: state := IDLE, buffer emptied, in-flight read discarded, row/remaining counters := 0.
REQ-022 Output values in the cycle after reset: cmd_ready=1, out_valid=0, out_last=0, busy=0, sram_ceb=0, sram_a=0, out_data=0.
REQ-023 Reset asserted mid-command SHALL abort the command; no word of it SHALL appear after reset deasserts.

Structure
REQ-024 Package sram_stream_pkg SHALL hold the FSM state typedef (IDLE, READ, DRAIN) and the buffer depth constant (2).
REQ-025 The output buffer SHALL be a sub-module, fifo2, a 2-entry valid/ready FIFO with occupancy output, parameterised by WIDTH.
REQ-026 The top level SHALL hold the FSM, the address and remaining counters, and the in-flight flag.

Verification
REQ-027 Start=5, count=4, out_ready=1, SRAM rows preloaded with row index -> out_data 5,6,7,8 on consecutive cycles; out_last on 8; first out_valid 3 cycles after acceptance.
REQ-028 Start=NUM_ROWS-2, count=4 -> rows NUM_ROWS-2, NUM_ROWS-1, 0, 1 in order.
REQ-029 Count=16 with out_ready toggling randomly, including 10-cycle stalls -> all 16 words in order, data stable during stalls, at most 2 reads outstanding plus buffered.
REQ-030 Count=0 -> cmd_ready stays 1, sram_ceb never asserts, out_valid never asserts.
REQ-031 RST pulsed for 1 cycle after 3 of 8 words are delivered -> next cycle idle outputs per REQ-022; a new command start=0, count=2 returns rows 0,1 only.
REQ-032 Count=NUM_ROWS (full sweep), out_ready=1 -> NUM_ROWS words, sram_web/sram_d/sram_m always 0.
